// File: rtl/uart_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_spi_bridge
// Brief    : Byte-stream protocol engine between a UART byte channel and an
//            SPI master byte channel (flash/boot host bridge). Decodes BOOT,
//            XFER, VERSION and STATUS commands, runs write-then-read SPI
//            transfers with chip-select control and a header timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_spi_bridge #(
    parameter int         LEN_BYTES      = 2,
    parameter int         NUM_CS         = 2,
    parameter logic [7:0] FILL_BYTE      = 8'hFF,
    parameter logic [7:0] VERSION        = 8'h02,
    parameter int         TIMEOUT_CYCLES = 12000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    output logic              uart_rx_ready,
    input  logic              uart_rx_break,
    output logic              uart_tx_valid,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_ready,
    output logic              spi_tx_valid,
    output logic [7:0]        spi_tx_data,
    input  logic              spi_tx_ready,
    input  logic              spi_rx_valid,
    input  logic [7:0]        spi_rx_data,
    output logic              spi_rx_ready,
    output logic [NUM_CS-1:0] spi_ss,
    output logic              boot,
    output logic [7:0]        boot_sel,
    output logic              led
);

    localparam int         LW           = 8 * LEN_BYTES;
    // Index of the last XFER header byte (cs + two length fields).
    localparam logic [3:0] c_xfer_last  = 4'(2 * LEN_BYTES);
    localparam logic [3:0] c_num_cs4    = 4'(NUM_CS);
    localparam logic [31:0] c_idle_last = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_RESP = 3'd2,
        S_TX   = 3'd3,
        S_RX   = 3'd4,
        S_BOOT = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_is_boot;
    logic [3:0]        r_hcnt;
    logic [7:0]        r_cs;
    logic [LW-1:0]     r_txlen;
    logic [LW-1:0]     r_rxlen;
    logic [LW-1:0]     r_cnt;
    logic [LW-1:0]     r_issued;
    logic [31:0]       r_idle;
    logic [7:0]        r_resp;
    logic [NUM_CS-1:0] r_ss;
    logic              r_boot;
    logic [7:0]        r_boot_sel;

    logic              w_urx_hs;
    logic              w_utx_hs;
    logic              w_stx_hs;
    logic              w_srx_hs;
    logic              w_hdr_last;
    logic              w_timeout;
    logic              w_tx_last;
    logic              w_rx_last;
    logic [LW-1:0]     w_rxlen_full;
    logic [NUM_CS-1:0] w_ss_sel;

    assign w_urx_hs = uart_rx_valid && uart_rx_ready;
    assign w_utx_hs = uart_tx_valid && uart_tx_ready;
    assign w_stx_hs = spi_tx_valid && spi_tx_ready;
    assign w_srx_hs = spi_rx_valid && spi_rx_ready;

    assign w_tx_last = (r_cnt + LW'(1)) == r_txlen;
    assign w_rx_last = (r_cnt + LW'(1)) == r_rxlen;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_idle == c_idle_last);

    assign spi_ss   = r_ss;
    assign boot     = r_boot;
    assign boot_sel = r_boot_sel;
    assign led      = (r_state != S_IDLE);

    // Header decode: last-byte detect, full rxlen including the byte in flight, chip-select pattern
    always_comb begin
        w_hdr_last   = r_is_boot ? (r_hcnt == 4'd0) : (r_hcnt == c_xfer_last);
        w_rxlen_full = r_rxlen;
        w_rxlen_full[LW-1 -: 8] = uart_rx_data;
        w_ss_sel     = '1;
        for (int k = 0; k < NUM_CS; k++) begin
            w_ss_sel[k] = (r_cs != 8'(k));
        end
    end

    // Stream outputs per state; TX is a straight pass-through from UART to SPI
    always_comb begin
        uart_rx_ready = 1'b1;
        uart_tx_valid = 1'b0;
        uart_tx_data  = r_resp;
        spi_tx_valid  = 1'b0;
        spi_tx_data   = FILL_BYTE;
        spi_rx_ready  = 1'b1;
        case (r_state)
            S_RESP: begin
                uart_rx_ready = 1'b0;
                uart_tx_valid = 1'b1;
            end
            S_TX: begin
                // A byte arriving with a break is swallowed rather than sent to flash.
                spi_tx_valid  = uart_rx_valid && !uart_rx_break;
                spi_tx_data   = uart_rx_data;
                uart_rx_ready = spi_tx_ready || uart_rx_break;
            end
            S_RX: begin
                uart_rx_ready = 1'b0;
                spi_tx_valid  = (r_issued != r_rxlen);
                uart_tx_valid = spi_rx_valid;
                uart_tx_data  = spi_rx_data;
                spi_rx_ready  = uart_tx_ready;
            end
            default: ;
        endcase
    end

    // Next-state logic; break overrides every other event
    always_comb begin
        w_state_next = r_state;
        if (uart_rx_break) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_urx_hs) begin
                        w_state_next = (uart_rx_data <= 8'h01) ? S_HDR : S_RESP;
                    end
                end
                S_HDR: begin
                    if (w_urx_hs && w_hdr_last) begin
                        if (r_is_boot)                 w_state_next = S_BOOT;
                        else if (r_txlen != '0)        w_state_next = S_TX;
                        else if (w_rxlen_full != '0)   w_state_next = S_RX;
                        else                           w_state_next = S_IDLE;
                    end else if (!w_urx_hs && w_timeout) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_RESP: begin
                    if (w_utx_hs) w_state_next = S_IDLE;
                end
                S_TX: begin
                    if (w_srx_hs && w_tx_last) begin
                        w_state_next = (r_rxlen != '0) ? S_RX : S_IDLE;
                    end
                end
                S_RX: begin
                    if (w_utx_hs && w_rx_last) w_state_next = S_IDLE;
                end
                S_BOOT:  w_state_next = S_BOOT;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Datapath: header capture, counters, chip select and boot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_boot  <= 1'b0;
            r_hcnt     <= '0;
            r_cs       <= '0;
            r_txlen    <= '0;
            r_rxlen    <= '0;
            r_cnt      <= '0;
            r_issued   <= '0;
            r_idle     <= '0;
            r_resp     <= '0;
            r_ss       <= '1;
            r_boot     <= 1'b0;
            r_boot_sel <= '0;
        end else if (uart_rx_break) begin
            r_ss <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_urx_hs) begin
                        r_is_boot <= (uart_rx_data == 8'h00);
                        r_hcnt    <= '0;
                        r_idle    <= '0;
                        r_cs      <= '0;
                        r_txlen   <= '0;
                        r_rxlen   <= '0;
                        case (uart_rx_data)
                            8'h02:   r_resp <= VERSION;
                            8'h03:   r_resp <= {r_boot, 3'b000, c_num_cs4};
                            default: r_resp <= 8'hEE;
                        endcase
                    end
                end
                S_HDR: begin
                    if (w_urx_hs) begin
                        r_hcnt <= r_hcnt + 4'd1;
                        r_idle <= '0;
                        if (r_hcnt == 4'd0) r_cs <= uart_rx_data;
                        for (int i = 0; i < LEN_BYTES; i++) begin
                            if (r_hcnt == 4'(i + 1))             r_txlen[8*i +: 8] <= uart_rx_data;
                            if (r_hcnt == 4'(LEN_BYTES + 1 + i)) r_rxlen[8*i +: 8] <= uart_rx_data;
                        end
                        if (w_hdr_last) begin
                            r_cnt    <= '0;
                            r_issued <= '0;
                            if (r_is_boot) begin
                                r_boot     <= 1'b1;
                                r_boot_sel <= uart_rx_data;
                            end else if ((r_txlen != '0) || (w_rxlen_full != '0)) begin
                                r_ss <= w_ss_sel;
                            end
                        end
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                S_TX: begin
                    if (w_srx_hs) begin
                        if (w_tx_last) begin
                            r_cnt <= '0;
                            if (r_rxlen == '0) r_ss <= '1;
                        end else begin
                            r_cnt <= r_cnt + LW'(1);
                        end
                    end
                end
                S_RX: begin
                    if (w_stx_hs) r_issued <= r_issued + LW'(1);
                    if (w_utx_hs) begin
                        if (w_rx_last) begin
                            r_cnt <= '0;
                            r_ss  <= '1;
                        end else begin
                            r_cnt <= r_cnt + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_spi_bridge
// Brief    : Self-checking bench for uart_spi_bridge: command table, directed
//            corner sequences and randomized XFERs against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_spi_bridge;

    localparam int         LB   = 2;
    localparam int         NCS  = 2;
    localparam int         TO   = 100;
    localparam logic [7:0] FILL = 8'hFF;
    localparam logic [7:0] VER  = 8'h02;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           uart_rx_valid = 1'b0;
    logic [7:0]     uart_rx_data = 8'h00;
    logic           uart_rx_ready;
    logic           uart_rx_break = 1'b0;
    logic           uart_tx_valid;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_ready = 1'b0;
    logic           spi_tx_valid;
    logic [7:0]     spi_tx_data;
    logic           spi_tx_ready = 1'b0;
    logic           spi_rx_valid = 1'b0;
    logic [7:0]     spi_rx_data = 8'h00;
    logic           spi_rx_ready;
    logic [NCS-1:0] spi_ss;
    logic           boot;
    logic [7:0]     boot_sel;
    logic           led;

    uart_spi_bridge #(
        .LEN_BYTES(LB), .NUM_CS(NCS), .FILL_BYTE(FILL), .VERSION(VER), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
        .uart_rx_break(uart_rx_break),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
        .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data), .spi_tx_ready(spi_tx_ready),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .spi_rx_ready(spi_rx_ready),
        .spi_ss(spi_ss), .boot(boot), .boot_sel(boot_sel), .led(led)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic [7:0]     host_q[$];
    logic [7:0]     rsp_q[$];
    logic [7:0]     rsp_gen[$];
    logic [7:0]     spi_log[$];
    logic [7:0]     utx_log[$];
    logic [7:0]     pay_q[$];
    logic [NCS-1:0] ss_log[$];
    bit             ss_low_seen = 0;
    bit             host_hold = 0;
    bit             host_rand = 0;
    bit             stx_rand = 0;
    bit             brk_now = 0;
    int             utx_mode = 0;
    logic           led_s = 1'b0;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] rsp;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive the environment at negedge, sample, then log handshakes.
    task automatic step();
        logic [7:0] r;
        @(negedge clk);
        if (!host_hold)
            uart_rx_valid = (host_q.size() > 0) && (!host_rand || $urandom_range(3) != 0);
        uart_rx_data  = (host_q.size() > 0) ? host_q[0] : 8'h00;
        case (utx_mode)
            0:       uart_tx_ready = 1'b1;
            1:       uart_tx_ready = (cyc % 3 == 0);
            default: uart_tx_ready = ($urandom_range(1) == 1);
        endcase
        spi_tx_ready  = stx_rand ? ($urandom_range(1) == 1) : 1'b1;
        spi_rx_valid  = (rsp_q.size() > 0);
        spi_rx_data   = (rsp_q.size() > 0) ? rsp_q[0] : 8'h00;
        uart_rx_break = brk_now;
        #1;
        led_s = led;
        if (spi_ss != '1) ss_low_seen = 1;
        if (uart_rx_valid && uart_rx_ready) begin
            void'(host_q.pop_front());
            host_hold = 0;
        end else begin
            host_hold = uart_rx_valid;
        end
        if (spi_tx_valid && spi_tx_ready) begin
            spi_log.push_back(spi_tx_data);
            ss_log.push_back(spi_ss);
            r = 8'($urandom);
            rsp_q.push_back(r);
            rsp_gen.push_back(r);
        end
        if (spi_rx_valid && spi_rx_ready) void'(rsp_q.pop_front());
        if (uart_tx_valid && uart_tx_ready) utx_log.push_back(uart_tx_data);
        cyc++;
    endtask

    task automatic clear_logs();
        rsp_gen.delete();
        spi_log.delete();
        utx_log.delete();
        ss_log.delete();
        ss_low_seen = 0;
    endtask

    task automatic run_idle(input int budget, input string name);
        bit done = 0;
        bit e;
        for (int n = 0; n < budget && !done; n++) begin
            e = (host_q.size() == 0);
            step();
            if (e && led_s == 1'b0) done = 1;
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic drain_host(input int budget);
        for (int n = 0; n < budget && host_q.size() > 0; n++) step();
    endtask

    task automatic push_xfer(input int cs, input int tx, input int rx);
        host_q.push_back(8'h01);
        host_q.push_back(8'(cs));
        for (int i = 0; i < LB; i++) host_q.push_back(8'(tx >> (8 * i)));
        for (int i = 0; i < LB; i++) host_q.push_back(8'(rx >> (8 * i)));
        foreach (pay_q[i]) host_q.push_back(pay_q[i]);
    endtask

    // Transaction model: SPI sees payload then rx FILL bytes, all under one
    // chip select; UART gets back the slave's answers to the FILL bytes.
    task automatic run_xfer(input string tag, input int cs, input int tx, input int rx);
        logic [NCS-1:0] exp_ss;
        logic [7:0]     exp_b;
        clear_logs();
        push_xfer(cs, tx, rx);
        run_idle(4000 + 8 * (tx + rx), tag);
        exp_ss = '1;
        if (cs < NCS) exp_ss[cs] = 1'b0;
        check({tag, "_spi_cnt"}, 32'(spi_log.size()), 32'(tx + rx));
        for (int i = 0; i < tx + rx && i < spi_log.size(); i++) begin
            exp_b = (i < tx) ? pay_q[i] : FILL;
            check($sformatf("%s_spi%0d", tag, i), 32'(spi_log[i]), 32'(exp_b));
            check($sformatf("%s_ss%0d", tag, i), 32'(ss_log[i]), 32'(exp_ss));
        end
        check({tag, "_utx_cnt"}, 32'(utx_log.size()), 32'(rx));
        for (int i = 0; i < rx && i < utx_log.size() && tx + i < rsp_gen.size(); i++)
            check($sformatf("%s_utx%0d", tag, i), 32'(utx_log[i]), 32'(rsp_gen[tx + i]));
        check({tag, "_ss_after"}, 32'(spi_ss), 32'({NCS{1'b1}}));
        check({tag, "_ss_low_seen"}, 32'(ss_low_seen), 32'((tx + rx > 0) && (cs < NCS)));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_ss", 32'(spi_ss), 32'({NCS{1'b1}}));
        check("rst_boot", 32'(boot), 32'd0);
        check("rst_boot_sel", 32'(boot_sel), 32'd0);
        check("rst_utx_valid", 32'(uart_tx_valid), 32'd0);
        check("rst_stx_valid", 32'(spi_tx_valid), 32'd0);
        check("rst_urx_ready", 32'(uart_rx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- single-byte command table ----------------
        vecs[0] = '{8'h02, VER};
        vecs[1] = '{8'h03, {1'b0, 3'b000, 4'(NCS)}};
        vecs[2] = '{8'h04, 8'hEE};
        vecs[3] = '{8'hFF, 8'hEE};
        vecs[4] = '{8'h7E, 8'hEE};
        for (int i = 0; i < 5; i++) begin
            utx_mode = i % 3;
            clear_logs();
            host_q.push_back(vecs[i].cmd);
            run_idle(60, $sformatf("cmd%0d", i));
            check($sformatf("cmd%0d_cnt", i), 32'(utx_log.size()), 32'd1);
            if (utx_log.size() > 0)
                check($sformatf("cmd%0d_rsp", i), 32'(utx_log[0]), 32'(vecs[i].rsp));
            check($sformatf("cmd%0d_nospi", i), 32'(spi_log.size()), 32'd0);
        end
        utx_mode = 0;

        // ---------------- directed XFERs ----------------
        pay_q = '{8'h9F, 8'h00, 8'h00};
        run_xfer("x_cs1", 1, 3, 2);
        pay_q.delete();
        run_xfer("x_zero", 0, 0, 0);
        run_xfer("x_rx1", 0, 0, 1);
        utx_mode = 1;
        run_xfer("x_bp", 0, 0, 4);
        utx_mode = 0;
        pay_q = '{8'h11, 8'h22};
        run_xfer("x_cs_oor", 5, 2, 1);
        run_xfer("x_big", 1, 2, 300);

        // ---------------- randomized XFERs ----------------
        host_rand = 1;
        stx_rand  = 1;
        utx_mode  = 2;
        for (int t = 0; t < 25; t++) begin
            int cs, tx, rx;
            cs = $urandom_range(2);
            tx = $urandom_range(6);
            rx = $urandom_range(6);
            pay_q.delete();
            for (int i = 0; i < tx; i++) pay_q.push_back(8'($urandom));
            run_xfer($sformatf("rnd%0d", t), cs, tx, rx);
        end
        host_rand = 0;
        stx_rand  = 0;
        utx_mode  = 0;

        // ---------------- header timeout ----------------
        clear_logs();
        host_q.push_back(8'h01);
        host_q.push_back(8'h00);
        drain_host(20);
        repeat (TO) step();
        check("to_hdr_still", 32'(led_s), 32'd1);
        step();
        check("to_idle", 32'(led_s), 32'd0);

        // ---------------- break mid-TX ----------------
        clear_logs();
        pay_q = '{8'hA1, 8'hA2};
        push_xfer(0, 4, 0);
        drain_host(50);
        repeat (4) step();
        check("brk_in_tx", 32'(led_s), 32'd1);
        check("brk_ss_low", 32'(spi_ss), 32'(2'b10));
        brk_now = 1;
        step();
        brk_now = 0;
        step();
        check("brk_ss_high", 32'(spi_ss), 32'(2'b11));
        check("brk_idle", 32'(led_s), 32'd0);
        clear_logs();
        host_q.push_back(8'h02);
        run_idle(60, "brk_ver");
        check("brk_ver_cnt", 32'(utx_log.size()), 32'd1);
        if (utx_log.size() > 0) check("brk_ver_rsp", 32'(utx_log[0]), 32'(VER));

        // Break coincident with a command byte: consumed, not answered.
        clear_logs();
        host_q.push_back(8'h02);
        brk_now = 1;
        step();
        brk_now = 0;
        repeat (5) step();
        check("brk_hs_consumed", 32'(host_q.size()), 32'd0);
        check("brk_hs_norsp", 32'(utx_log.size()), 32'd0);
        check("brk_hs_idle", 32'(led_s), 32'd0);

        // ---------------- BOOT ----------------
        clear_logs();
        host_q.push_back(8'h00);
        host_q.push_back(8'h05);
        drain_host(20);
        step();
        check("boot_flag", 32'(boot), 32'd1);
        check("boot_sel", 32'(boot_sel), 32'd5);
        check("boot_busy", 32'(led_s), 32'd1);
        host_q.push_back(8'h02);
        repeat (10) step();
        check("boot_held", 32'(led_s), 32'd1);
        check("boot_ignores_cmd", 32'(utx_log.size()), 32'd0);
        brk_now = 1;
        step();
        brk_now = 0;
        step();
        check("boot_brk_idle", 32'(led_s), 32'd0);
        check("boot_kept", 32'(boot), 32'd1);
        check("boot_sel_kept", 32'(boot_sel), 32'd5);
        clear_logs();
        host_q.push_back(8'h03);
        run_idle(60, "boot_status");
        check("boot_status_cnt", 32'(utx_log.size()), 32'd1);
        if (utx_log.size() > 0)
            check("boot_status_rsp", 32'(utx_log[0]), 32'({1'b1, 3'b000, 4'(NCS)}));

        // ---------------- async reset mid-TX ----------------
        clear_logs();
        pay_q = '{8'h5A, 8'hC3};
        push_xfer(1, 4, 2);
        drain_host(50);
        step();
        check("rst2_in_tx", 32'(spi_ss), 32'(2'b01));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_led", 32'(led), 32'd0);
        check("rst2_ss", 32'(spi_ss), 32'({NCS{1'b1}}));
        check("rst2_boot", 32'(boot), 32'd0);
        check("rst2_boot_sel", 32'(boot_sel), 32'd0);
        check("rst2_utx_valid", 32'(uart_tx_valid), 32'd0);
        check("rst2_stx_valid", 32'(spi_tx_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
